// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM state encoding and sizing helper for the TDC fine-code
// calibration block (tdc_fine_cal / tdc_fine_lane).
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tdc_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_fine_lane.sv
// tdc_fine_lane: one channel of the fine-code calibrator. Holds the
// thermometer shift register, counts the ones it shifts out BPC at a time and
// presents the resulting fine code / all-zero flag.
// Optional macro TDC_BUBBLE_FIX_EN: 3-tap majority bubble filter on the code
// as it is loaded (no extra cycle; the filter sits in the load path).
module tdc_fine_lane
  import tdc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BPC   = 1,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_code,
  output logic [OUT_W-1:0] o_fine,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_shreg;
  logic [OUT_W:0]   r_acc;
  logic [WIDTH-1:0] w_load_val;
  logic [OUT_W:0]   w_pop;

`ifdef TDC_BUBBLE_FIX_EN
  // Pad with a 1 below bit 0 and a 0 above the MSB so the edges of a clean
  // thermometer code pass through the filter unchanged.
  logic [WIDTH+1:0] w_ext;
  assign w_ext = {1'b0, i_code, 1'b1};

  // Majority of each bit and its two neighbours removes isolated bubbles.
  always_comb begin
    w_load_val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_load_val[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) |
                      (w_ext[i+1] & w_ext[i+2]);
    end
  end
`else
  assign w_load_val = i_code;
`endif

  // Popcount of the BPC bits leaving the register this cycle.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < BPC; i++) begin
      w_pop = w_pop + {{OUT_W{1'b0}}, r_shreg[i]};
    end
  end

  // Shift register and accumulator; clear beats load beats shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_acc   <= '0;
    end else if (i_clr) begin
      r_shreg <= '0;
      r_acc   <= '0;
    end else if (i_load) begin
      r_shreg <= w_load_val;
      r_acc   <= '0;
    end else if (i_shift) begin
      r_shreg <= r_shreg >> BPC;
      r_acc   <= r_acc + w_pop;
    end
  end

  // Fine code is sum-1; a full-scale sum of WIDTH wraps cleanly to WIDTH-1 in
  // OUT_W bits, and an empty sum is forced to 0 with the zero flag raised.
  assign o_zero = (r_acc == '0);
  assign o_fine = o_zero ? '0 : (r_acc[OUT_W-1:0] - {{(OUT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/tdc_fine_cal.sv
// tdc_fine_cal: multi-channel TDC thermometer-to-fine-code calibrator.
// Accepts one CH*WIDTH code vector in IDLE, shifts it out BPC bits per cycle
// for WIDTH/BPC cycles while counting ones per channel, then presents
// sum-1 per channel until the consumer takes it. flush aborts at any time.
// Optional macro TDC_BUBBLE_FIX_EN enables the load-time bubble filter in
// each lane.
module tdc_fine_cal
  import tdc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CH    = 4,
  parameter int BPC   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH*WIDTH-1:0]         in_code,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH*clog2(WIDTH)-1:0]  out_fine,
  output logic [CH-1:0]               out_zero,
  output logic                        busy
);

  localparam int OUT_W = clog2(WIDTH);
  localparam int STEPS = WIDTH / BPC;
  localparam int CNT_W = OUT_W + 1;

  tdc_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [CH*OUT_W-1:0] r_out_fine;
  logic [CH-1:0]       r_out_zero;

  logic                w_accept;
  logic                w_shift;
  logic                w_last;
  logic [CH*OUT_W-1:0] w_fine;
  logic [CH-1:0]       w_zero;

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_shift  = (r_state == SHIFT) & ~flush;
  assign w_last   = (r_cnt == CNT_W'(STEPS - 1));

  genvar c;
  generate
    for (c = 0; c < CH; c++) begin : g_lane
      tdc_fine_lane #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .OUT_W (OUT_W)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_clr   (flush),
        .i_code  (in_code[c*WIDTH +: WIDTH]),
        .o_fine  (w_fine[c*OUT_W +: OUT_W]),
        .o_zero  (w_zero[c])
      );
    end
  endgenerate

  // Control FSM with registered handshake/result outputs. in_ready is a
  // register so it stays low through reset and rises on the first edge after.
  // The result is captured on the first DONE cycle (the final shift lands in
  // the accumulators on the SHIFT->DONE edge), so out_valid follows one cycle
  // later and stays frozen until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_fine  <= '0;
      r_out_zero  <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_fine  <= '0;
      r_out_zero  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state    <= SHIFT;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_fine  <= w_fine;
            r_out_zero  <= w_zero;
          end else if (out_ready) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_fine  <= '0;
            r_out_zero  <= '0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_fine  = r_out_fine;
  assign out_zero  = r_out_zero;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_tdc_fine_cal.sv
// tb_tdc_fine_cal: scoreboard bench for tdc_fine_cal (WIDTH=16, CH=4, BPC=1)
// plus a small BPC=4 single-channel instance for the wide-step latency case.
module tb_tdc_fine_cal;

  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int OW  = 4;
  localparam int LAT = W + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [CH*W-1:0] in_code = '0;
  logic            in_ready, out_valid, busy;
  logic [CH*OW-1:0] out_fine;
  logic [CH-1:0]   out_zero;

  logic            flush4 = 1'b0;
  logic            in_valid4 = 1'b0;
  logic            out_ready4 = 1'b1;
  logic [W-1:0]    in_code4 = '0;
  logic            in_ready4, out_valid4, busy4;
  logic [OW-1:0]   out_fine4;
  logic [0:0]      out_zero4;

  tdc_fine_cal #(.WIDTH(W), .CH(CH), .BPC(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_code(in_code), .out_valid(out_valid),
    .out_ready(out_ready), .out_fine(out_fine), .out_zero(out_zero), .busy(busy)
  );

  tdc_fine_cal #(.WIDTH(W), .CH(1), .BPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .in_valid(in_valid4),
    .in_ready(in_ready4), .in_code(in_code4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_fine(out_fine4), .out_zero(out_zero4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [CH*OW-1:0] fine;
    logic [CH-1:0]    zero;
    int               acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic prev_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit i of the (optionally filtered) code, with 1 below and 0 above.
  function automatic int tbit(input logic [W-1:0] c, input int i);
    if (i < 0) return 1;
    if (i >= W) return 0;
    return int'(c[i]);
  endfunction

  function automatic int ones(input logic [W-1:0] c);
    int n = 0;
    for (int i = 0; i < W; i++) begin
`ifdef TDC_BUBBLE_FIX_EN
      if (tbit(c, i-1) + tbit(c, i) + tbit(c, i+1) >= 2) n++;
`else
      n += tbit(c, i);
`endif
    end
    return n;
  endfunction

  function automatic exp_t model(input logic [CH*W-1:0] v);
    exp_t e;
    int n;
    e.fine = '0;
    e.zero = '0;
    e.acc  = 0;
    for (int c = 0; c < CH; c++) begin
      n = ones(v[c*W +: W]);
      if (n == 0) e.zero[c] = 1'b1;
      else        e.fine[c*OW +: OW] = OW'(n - 1);
    end
    return e;
  endfunction

  // Monitor: a rising out_valid pops the scoreboard; a held out_valid must not move.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      q.delete();
      prev_v <= 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_v) begin
          chk("result_expected", 64'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("out_fine", out_fine, e.fine);
            chk("out_zero", out_zero, e.zero);
            chk("latency", 64'(cyc - e.acc), LAT);
            cur <= e;
          end
        end else begin
          chk("hold_fine", out_fine, cur.fine);
          chk("hold_zero", out_zero, cur.zero);
        end
        chk("in_ready_in_done", in_ready, 0);
        chk("busy_in_done", busy, 1);
      end else begin
        chk("idle_outputs_zero", {out_fine, out_zero}, 0);
      end
      prev_v <= out_valid;
    end
  end

  task automatic send(input logic [CH*W-1:0] v, input bit push);
    exp_t e;
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_code  = v;
    e = model(v);
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (push) q.push_back(e);
    chk("busy_after_accept", busy, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = {$urandom, $urandom};
  endtask

  task automatic wait_result(input int hold);
    int g = 0;
    out_ready = (hold == 0);
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("result_arrived", out_valid, 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        in_code  = {$urandom, $urandom};
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop_after_take", out_valid, 0);
    chk("in_ready_after_take", in_ready, 1);
  endtask

  function automatic logic [W-1:0] rand_code();
    logic [31:0] t;
    int k;
    k = $urandom_range(0, 16);
    t = (32'd1 << k) - 32'd1;
    if ($urandom_range(0, 3) == 0) t = t ^ (32'd1 << $urandom_range(0, W-1));
    if ($urandom_range(0, 7) == 0) t = $urandom;
    return t[W-1:0];
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [CH*W-1:0] v;
    int a, g;
    logic [W-1:0] c4;
    logic [W-1:0] codes4 [3];

    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_fine", out_fine, 0);
    chk("rst_out_zero", out_zero, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_first_edge", in_ready, 1);
    chk("idle_not_busy", busy, 0);

    // ch0 0x00FF, ch1 all-zero, ch2 all-one, ch3 bubbled 0x00F7
    v = {16'h00F7, 16'hFFFF, 16'h0000, 16'h00FF};
    send(v, 1);
    wait_result(0);

    // Consumer stalls five cycles with in_valid pulses that must be ignored
    v = {rand_code(), rand_code(), rand_code(), rand_code()};
    send(v, 1);
    wait_result(5);

    // Flush in SHIFT cycle 8: no result, then a clean transaction
    v = {16'h0FFF, 16'h00FF, 16'h000F, 16'h0003};
    send(v, 0);
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_to_idle_busy", busy, 0);
    chk("flush_to_idle_ready", in_ready, 1);
    repeat (25) @(negedge clk);
    v = {16'h7FFF, 16'h0001, 16'h003F, 16'h01FF};
    send(v, 1);
    wait_result(2);

    // Flush beats a simultaneous accept
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_blocks_accept", busy, 0);

    // Reset in the middle of SHIFT discards the transaction
    send({rand_code(), rand_code(), rand_code(), rand_code()}, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset_busy", busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(negedge clk);

    for (int t = 0; t < 30; t++) begin
      v = {rand_code(), rand_code(), rand_code(), rand_code()};
      send(v, 1);
      wait_result($urandom_range(0, 4));
    end

    // BPC=4 instance: four shift cycles, result one cycle later
    codes4[0] = 16'h0FFF;
    codes4[1] = 16'h0000;
    codes4[2] = rand_code();
    for (int i = 0; i < 3; i++) begin
      c4 = codes4[i];
      @(negedge clk);
      chk("bpc4_in_ready", in_ready4, 1);
      in_valid4 = 1'b1;
      in_code4  = c4;
      @(posedge clk);
      #1 a = cyc;
      @(negedge clk);
      in_valid4 = 1'b0;
      g = 0;
      while (!out_valid4 && g < 50) begin
        @(negedge clk);
        g++;
      end
      chk("bpc4_valid", out_valid4, 1);
      chk("bpc4_latency", 64'(cyc - a), W/4 + 1);
      chk("bpc4_fine", out_fine4, (ones(c4) == 0) ? 0 : ones(c4) - 1);
      chk("bpc4_zero", out_zero4, 64'(ones(c4) == 0));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_fine_cal.md
TDC_FINE_CAL -- requirements
Module: tdc_fine_cal

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning thermometer bits per channel; WIDTH is a power of 2 and at least 4.
REQ-002 SHALL have parameter CH, default 4, meaning the number of independent channels.
REQ-003 SHALL have parameter BPC, default 1, meaning bits consumed per cycle; BPC is a power of 2 and divides WIDTH.
REQ-004 SHALL have local parameter OUT_W = clog2(WIDTH).
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-008 SHALL have port in_valid, input, 1 bit: code vector present.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept.
REQ-010 SHALL have port in_code, input, CH*WIDTH bits: channel c occupies bits [c*WIDTH +: WIDTH], LSB first.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts.
REQ-013 SHALL have port out_fine, output, CH*OUT_W bits: per-channel fine code.
REQ-014 SHALL have port out_zero, output, CH bits: per-channel all-zero code flag.
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL treat in_valid & in_ready & !flush as accept: load every channel shift register, clear accumulators and the cycle counter, then go to SHIFT.
REQ-019 In SHIFT, SHALL add popcount(shreg[BPC-1:0]) to each accumulator per cycle, shift each register right by BPC, and increment the counter.
REQ-020 SHALL stay in SHIFT exactly WIDTH/BPC cycles, then go to DONE.
REQ-021 SHALL size each accumulator OUT_W+1 bits so that a sum of WIDTH does not wrap.
REQ-022 In DONE, SHALL hold out_valid = 1 and out_fine[c] = sum[c]-1, truncated to OUT_W.
REQ-023 When sum[c] = 0, SHALL give out_fine[c] = 0 and out_zero[c] = 1; otherwise out_zero[c] = 0.
REQ-024 SHALL set the latency from the accept edge to the first out_valid cycle to WIDTH/BPC+1 cycles.
REQ-025 SHALL hold out_fine and out_zero stable while out_valid & !out_ready.
REQ-026 On out_valid & out_ready, SHALL return to IDLE; in_ready becomes 1 in the next cycle, with no same-cycle re-accept.
REQ-027 On flush in any state, SHALL go to IDLE next cycle, clear accumulators and counter, and emit no output; flush has priority over accept and over the output handshake.
REQ-028 SHALL ignore in_code while not in IDLE.
REQ-029 SHALL drive out_valid = 0 and out_fine/out_zero = 0 outside DONE.

Reset
REQ-030 On rst_n low, SHALL asynchronously set state IDLE, clear all shift registers, accumulators and counter, and drive out_valid = 0, out_fine = 0, out_zero = 0, busy = 0, in_ready = 0.
REQ-031 SHALL drive in_ready = 1 from the first clock edge after rst_n deasserts.
REQ-032 Reset mid-SHIFT or mid-DONE SHALL discard the result.

Configuration
REQ-033 With TDC_BUBBLE_FIX_EN defined, SHALL replace each loaded bit i with majority(b[i-1], b[i], b[i+1]), taking b[-1] = 1 and b[WIDTH] = 0, at load time only.
REQ-034 Without TDC_BUBBLE_FIX_EN, SHALL load raw bits, adding no logic and no latency in either case.

Structure
REQ-035 SHALL keep the FSM state enum and the clog2 helper function in the shared package tdc_pkg.
REQ-036 SHALL implement one sub-module, tdc_fine_lane (shift register, popcount, accumulator, optional bubble fix), instantiated CH times; the top holds the FSM, counter and handshake.

Verification (WIDTH=16, CH=4, BPC=1 unless stated)
REQ-037 SHALL cover: ch0 code 0x00FF, out_ready=1 -> out_valid 17 cycles after accept, out_fine[0]=7, out_zero[0]=0.
REQ-038 SHALL cover: codes 0x0000 and 0xFFFF -> out_fine=0 with out_zero=1, and out_fine=15 with out_zero=0.
REQ-039 SHALL cover: out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored.
REQ-040 SHALL cover: flush at SHIFT cycle 8 -> IDLE next cycle, no out_valid, next accept produces a correct result.
REQ-041 SHALL cover: with TDC_BUBBLE_FIX_EN, code 0x00F7 -> out_fine=7; without TDC_BUBBLE_FIX_EN -> out_fine=6.
REQ-042 SHALL cover: BPC=4, code 0x0FFF -> latency 5 cycles, out_fine=11.
